// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared constants for the bit-serial adder:
//   DEFAULT_WIDTH  - default operand width
//   ST_IDLE/RUN/DONE - FSM state encodings (2-bit)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit combinational full adder cell.
// Ports:
//   a, b, cin  - input bits
//   s          - sum bit  (a ^ b ^ cin)
//   cout       - carry out (majority of a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: one full-adder step per clock, LSB first. An accepted
// start captures a, b and cin; WIDTH RUN cycles later the FSM passes through
// DONE, on whose edge the result registers update and done pulses for one
// cycle. The result is then held until the next accepted start completes.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   start - begin an addition (honoured only in IDLE)
//   a, b  - WIDTH-bit operands
//   cin   - carry in
//   busy  - high while in RUN or DONE
//   done  - one-cycle result-valid pulse
//   sum   - registered WIDTH-bit result
//   cout  - registered carry out of the MSB
//   ovf   - registered signed overflow (only with SERIAL_ADDER_OVF_EN)
//
// Build option: define SERIAL_ADDER_OVF_EN to add the ovf output.
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    // One extra bit so the count can reach WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             fa_sum_s;
    logic             fa_cout_s;
`ifdef SERIAL_ADDER_OVF_EN
    logic             msb_cin_r;
    logic             ovf_r;
`endif

    full_adder u_fa (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .cin  (carry_r),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    // FSM, datapath shift registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            res_r     <= '0;
            carry_r   <= 1'b0;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sum_r     <= '0;
            cout_r    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            msb_cin_r <= 1'b0;
            ovf_r     <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Blocking start during the done pulse makes the earliest
                    // restart the cycle after done.
                    if (start && !done_r) begin
                        state_r <= ST_RUN;
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        res_r   <= '0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_r     <= a_r >> 1;
                    b_r     <= b_r >> 1;
                    res_r   <= {fa_sum_s, res_r[WIDTH-1:1]};
                    carry_r <= fa_cout_s;
                    cnt_r   <= cnt_r + CW'(1);
`ifdef SERIAL_ADDER_OVF_EN
                    // The value left here after the last step is the carry
                    // into the MSB.
                    msb_cin_r <= carry_r;
`endif
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    sum_r   <= res_r;
                    cout_r  <= carry_r;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_r   <= msb_cin_r ^ carry_r;
`endif
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_r;
`endif

endmodule
